pcecd_cmd_rx: RTL and testbench
===============================

PCECD_CMD_RX -- requirements
Module: pcecd_cmd_rx

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT_CYC, default 65535: cycles allowed per handshake half before abort.
REQ-002 SHALL have parameter BUF_DEPTH, default 16: command buffer bytes; minimum 12.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_start, input, 1: the drive has entered PHASE_COMMAND; one-cycle pulse.
REQ-006 SHALL have port i_abort, input, 1: bus RST seen; level.
REQ-007 SHALL have port i_db, input, 8: host data bus, the $1801 write value.
REQ-008 SHALL have port i_ack, input, 1: host ACK level, $1802 bit 7.
REQ-009 SHALL have port o_req, output, 1: drive REQ for the command phase.
REQ-010 SHALL have port o_cmd_valid, output, 1: a complete command is buffered.
REQ-011 SHALL have port i_cmd_taken, input, 1: consumer accepts the command; one-cycle pulse.
REQ-012 SHALL have ports o_cmd_opcode (output, 8) and o_cmd_len (output, 4): byte 0 and the received byte count.
REQ-013 SHALL have ports i_rd_addr (input, 4) and o_rd_data (output, 8): combinational buffer read.
REQ-014 SHALL have ports o_bad_opcode, o_timeout and o_busy (each output, 1): unknown opcode; handshake timeout, one-cycle pulse; state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, REQ_WAIT, ACK_WAIT, DONE.
REQ-016 SHALL, on i_start in IDLE, next cycle enter REQ_WAIT with o_req=1, byte position 0, o_bad_opcode=0.
REQ-017 SHALL ignore i_start in any state other than IDLE.
REQ-018 SHALL, in REQ_WAIT with i_ack=1, store i_db at the current position, increment the position, drive o_req=0 and enter ACK_WAIT, all on the next cycle.
REQ-019 SHALL, when storing byte 0, set the expected length: 0x00-0x1F gives 6; 0x20-0x5F gives 10; 0xA0-0xBF gives 12; 0xD8-0xDF (vendor) gives 10; any other value gives 1 and sets o_bad_opcode=1.
REQ-020 SHALL, in ACK_WAIT with i_ack=0, enter DONE with o_cmd_valid=1 if the position equals the expected length; otherwise re-enter REQ_WAIT with o_req=1, on the next cycle in both cases.
REQ-021 SHALL hold o_cmd_valid, o_cmd_opcode and o_cmd_len stable in DONE until i_cmd_taken, then return to IDLE on the next cycle.
REQ-022 SHALL retain buffer contents after DONE until the next byte-0 write.
REQ-023 SHALL NOT let the position exceed BUF_DEPTH-1; the expected length bounds it.
REQ-024 SHALL run a timeout counter in REQ_WAIT and ACK_WAIT, cleared on every state change.
REQ-025 SHALL, when the counter reaches ACK_TIMEOUT_CYC, pulse o_timeout for one cycle, drop o_req and enter IDLE.
REQ-026 SHALL, on i_abort=1 in any state, enter IDLE on the next cycle with o_req=0, o_cmd_valid=0 and position 0; abort overrides i_ack, i_start and i_cmd_taken in the same cycle.
REQ-027 SHALL register all outputs except o_rd_data.

Reset
REQ-028 SHALL, while i_rst_n=0, immediately force state IDLE, o_req=0, o_cmd_valid=0, o_cmd_opcode=0, o_cmd_len=0, o_bad_opcode=0, o_timeout=0, o_busy=0, counters 0.
REQ-029 SHALL leave buffer contents undefined after reset; o_rd_data is don't-care until the first command.
REQ-030 SHALL, when reset is asserted mid-handshake, drop o_req immediately and never complete that command.

Structure
REQ-031 SHALL place the state enum, opcode range constants and length constants in shared package pcecd_pkg.
REQ-032 SHALL implement the opcode-to-length map as sub-module pcecd_cmd_len_decode: inputs opcode; outputs length[3:0] and bad.

Verification
REQ-033 SHALL verify TEST UNIT READY: i_start, then 6 REQ/ACK cycles with bytes 00 00 00 00 00 00 -> o_cmd_valid one cycle after the last ACK falls, o_cmd_len=6, o_cmd_opcode=0x00.
REQ-034 SHALL verify vendor read: D8 followed by 9 bytes 01..09 -> o_cmd_len=10; i_rd_addr=9 gives o_rd_data=0x09; i_cmd_taken returns IDLE next cycle.
REQ-035 SHALL verify bad opcode: first byte 0xF0 -> o_bad_opcode=1, o_cmd_len=1, DONE after ACK falls, no second REQ.
REQ-036 SHALL verify timeout: ACK_TIMEOUT_CYC=8, i_start, ACK never raised -> o_timeout pulse 8 cycles after REQ rises, o_req=0, state IDLE.
REQ-037 SHALL verify abort: i_abort asserted after byte 3 of a 10-byte command -> IDLE next cycle, o_req=0; a new i_start restarts at position 0.
REQ-038 SHALL verify async reset: i_rst_n low mid-REQ_WAIT between clock edges -> o_req=0 before the next edge, o_busy=0.

Source files
------------

// File: rtl/pcecd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcecd_pkg
// Purpose : Shared types and constants for the PC-Engine CD command receiver.
// Revision: 1.0
// ============================================================================
package pcecd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_WAIT = 2'd1,
    ST_ACK_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } pcecd_state_e;

  // SCSI command group opcode ranges (inclusive)
  localparam logic [7:0] c_OP_G0_LO = 8'h00;
  localparam logic [7:0] c_OP_G0_HI = 8'h1F;
  localparam logic [7:0] c_OP_G1_LO = 8'h20;
  localparam logic [7:0] c_OP_G1_HI = 8'h5F;
  localparam logic [7:0] c_OP_G5_LO = 8'hA0;
  localparam logic [7:0] c_OP_G5_HI = 8'hBF;
  localparam logic [7:0] c_OP_VU_LO = 8'hD8;
  localparam logic [7:0] c_OP_VU_HI = 8'hDF;

  localparam logic [3:0] c_LEN_G0  = 4'd6;
  localparam logic [3:0] c_LEN_G1  = 4'd10;
  localparam logic [3:0] c_LEN_G5  = 4'd12;
  localparam logic [3:0] c_LEN_VU  = 4'd10;
  localparam logic [3:0] c_LEN_BAD = 4'd1;

  function automatic logic in_range(input logic [7:0] op,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcecd_cmd_len_decode.sv
`default_nettype none
// ============================================================================
// Module  : pcecd_cmd_len_decode
// Purpose : Maps a command opcode to its CDB length; flags unknown opcodes.
// Revision: 1.0
// ============================================================================
module pcecd_cmd_len_decode
  import pcecd_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [3:0] o_length,
  output logic       o_bad
);

  always_comb begin
    o_length = c_LEN_BAD;
    o_bad    = 1'b1;
    if (in_range(i_opcode, c_OP_G0_LO, c_OP_G0_HI)) begin
      o_length = c_LEN_G0;
      o_bad    = 1'b0;
    end else if (in_range(i_opcode, c_OP_G1_LO, c_OP_G1_HI)) begin
      o_length = c_LEN_G1;
      o_bad    = 1'b0;
    end else if (in_range(i_opcode, c_OP_G5_LO, c_OP_G5_HI)) begin
      o_length = c_LEN_G5;
      o_bad    = 1'b0;
    end else if (in_range(i_opcode, c_OP_VU_LO, c_OP_VU_HI)) begin
      o_length = c_LEN_VU;
      o_bad    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcecd_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module  : pcecd_cmd_rx
// Purpose : Command-phase REQ/ACK receiver; buffers one CDB for a consumer.
// Revision: 1.0
// ============================================================================
module pcecd_cmd_rx
  import pcecd_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYC = 65535,
  parameter int BUF_DEPTH       = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_db,
  input  logic       i_ack,
  output logic       o_req,
  output logic       o_cmd_valid,
  input  logic       i_cmd_taken,
  output logic [7:0] o_cmd_opcode,
  output logic [3:0] o_cmd_len,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_bad_opcode,
  output logic       o_timeout,
  output logic       o_busy
);

  localparam int            TW         = $clog2(ACK_TIMEOUT_CYC + 1);
  // Firing on the last count makes the abort land exactly ACK_TIMEOUT_CYC
  // cycles after the state was entered.
  localparam logic [TW-1:0] c_TMO_LAST = TW'(ACK_TIMEOUT_CYC - 1);

  pcecd_state_e  r_state, w_state_nxt;
  logic [3:0]    r_pos, w_pos_nxt;
  logic [3:0]    r_exp_len, w_exp_len_nxt;
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic [7:0]    r_opcode, w_opcode_nxt;
  logic          r_bad, w_bad_nxt;
  logic          w_timeout_nxt;
  logic          w_store;
  logic          w_tmo_hit;
  logic          r_req, r_valid, r_busy, r_timeout;
  logic [3:0]    w_dec_len;
  logic          w_dec_bad;
  logic [7:0]    w_rd_data;
  logic [7:0]    r_buf [BUF_DEPTH];

  pcecd_cmd_len_decode u_len_decode (
    .i_opcode (i_db),
    .o_length (w_dec_len),
    .o_bad    (w_dec_bad)
  );

  assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_exp_len_nxt = r_exp_len;
    w_opcode_nxt  = r_opcode;
    w_bad_nxt     = r_bad;
    w_timeout_nxt = 1'b0;
    w_store       = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_pos_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_REQ_WAIT;
            w_pos_nxt   = 4'd0;
            w_bad_nxt   = 1'b0;
          end
        end
        ST_REQ_WAIT: begin
          if (w_tmo_hit) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
          end else if (i_ack) begin
            w_store     = 1'b1;
            w_pos_nxt   = r_pos + 4'd1;
            w_state_nxt = ST_ACK_WAIT;
            if (r_pos == 4'd0) begin
              w_exp_len_nxt = w_dec_len;
              w_bad_nxt     = w_dec_bad;
              w_opcode_nxt  = i_db;
            end
          end
        end
        ST_ACK_WAIT: begin
          if (w_tmo_hit) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
          end else if (!i_ack) begin
            w_state_nxt = (r_pos == r_exp_len) ? ST_DONE : ST_REQ_WAIT;
          end
        end
        ST_DONE: begin
          if (i_cmd_taken) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_tmo_cnt_nxt = '0;
    if ((w_state_nxt == r_state) &&
        ((r_state == ST_REQ_WAIT) || (r_state == ST_ACK_WAIT))) begin
      w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_pos     <= 4'd0;
      r_exp_len <= 4'd0;
      r_tmo_cnt <= '0;
      r_opcode  <= 8'd0;
      r_bad     <= 1'b0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_exp_len <= w_exp_len_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_opcode  <= w_opcode_nxt;
      r_bad     <= w_bad_nxt;
      r_req     <= (w_state_nxt == ST_REQ_WAIT);
      r_valid   <= (w_state_nxt == ST_DONE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_timeout <= w_timeout_nxt;
    end
  end

  // Buffer is deliberately not reset; contents are meaningless until written.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (r_pos == 4'(i)) begin
          r_buf[i] <= i_db;
        end
      end
    end
  end

  always_comb begin
    w_rd_data = 8'd0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (i_rd_addr == 4'(i)) begin
        w_rd_data = r_buf[i];
      end
    end
  end

  assign o_req        = r_req;
  assign o_cmd_valid  = r_valid;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;
  assign o_bad_opcode = r_bad;
  assign o_cmd_opcode = r_opcode;
  assign o_cmd_len    = r_pos;
  assign o_rd_data    = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pcecd_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcecd_cmd_rx
// Purpose : Self-checking bench: host-side REQ/ACK driver plus command model.
// Revision: 1.0
// ============================================================================
module tb_pcecd_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_db = 8'd0;
  logic       i_ack = 1'b0;
  logic       i_cmd_taken = 1'b0;
  logic [3:0] i_rd_addr = 4'd0;
  logic       o_req, o_cmd_valid, o_bad_opcode, o_timeout, o_busy;
  logic [7:0] o_cmd_opcode, o_rd_data;
  logic [3:0] o_cmd_len;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] cmd_q[$];

  always #5 clk = ~clk;

  pcecd_cmd_rx #(.ACK_TIMEOUT_CYC(8), .BUF_DEPTH(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_db         (i_db),
    .i_ack        (i_ack),
    .o_req        (o_req),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_taken  (i_cmd_taken),
    .o_cmd_opcode (o_cmd_opcode),
    .o_cmd_len    (o_cmd_len),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_bad_opcode (o_bad_opcode),
    .o_timeout    (o_timeout),
    .o_busy       (o_busy)
  );

  // CDB length rule straight from the opcode table; 1 means unknown opcode.
  function automatic int model_len(input logic [7:0] op);
    if (op <= 8'h1F)                  return 6;
    if (op >= 8'h20 && op <= 8'h5F)   return 10;
    if (op >= 8'hA0 && op <= 8'hBF)   return 12;
    if (op >= 8'hD8 && op <= 8'hDF)   return 10;
    return 1;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Host side of n REQ/ACK handshakes using cmd_q; returns with ACK just dropped.
  task automatic send_bytes(input int n, input bit inject_start, output bit ok);
    int t;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (o_req !== 1'b1 && t < 30) begin
        @(negedge clk);
        t++;
      end
      if (o_req !== 1'b1) begin
        n_vec++; n_err++;
        $display("FAIL req_rise byte %0d: o_req=%b required 1", k, o_req);
        ok = 1'b0;
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_db    = cmd_q[k];
      i_ack   = 1'b1;
      i_start = inject_start && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      i_start = 1'b0;
      t = 0;
      while (o_req !== 1'b0 && t < 30) begin
        @(negedge clk);
        t++;
      end
      if (o_req !== 1'b0) begin
        n_vec++; n_err++;
        $display("FAIL req_fall byte %0d: o_req=%b required 0", k, o_req);
        i_ack = 1'b0;
        ok = 1'b0;
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_ack = 1'b0;
    end
  endtask

  // Called on the negedge one cycle after the last ACK fell.
  task automatic check_done(input string tag);
    int el;
    el = model_len(cmd_q[0]);
    n_vec++;
    if (o_cmd_valid !== 1'b1) begin
      n_err++; $display("FAIL %s valid: got %b required 1", tag, o_cmd_valid);
    end
    n_vec++;
    if (o_cmd_len !== 4'(el)) begin
      n_err++; $display("FAIL %s len: got %0d required %0d", tag, o_cmd_len, el);
    end
    n_vec++;
    if (o_cmd_opcode !== cmd_q[0]) begin
      n_err++; $display("FAIL %s opcode: got %h required %h", tag, o_cmd_opcode, cmd_q[0]);
    end
    n_vec++;
    if (o_bad_opcode !== (el == 1)) begin
      n_err++; $display("FAIL %s bad: got %b required %b", tag, o_bad_opcode, (el == 1));
    end
    n_vec++;
    if (o_req !== 1'b0) begin
      n_err++; $display("FAIL %s no_req: got %b required 0", tag, o_req);
    end
    for (int i = 0; i < el; i++) begin
      i_rd_addr = 4'(i);
      #1;
      n_vec++;
      if (o_rd_data !== cmd_q[i]) begin
        n_err++; $display("FAIL %s rd[%0d]: got %h required %h", tag, i, o_rd_data, cmd_q[i]);
      end
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_cmd_valid !== 1'b1 || o_cmd_len !== 4'(el)) begin
      n_err++; $display("FAIL %s hold: valid=%b len=%0d required 1/%0d", tag, o_cmd_valid, o_cmd_len, el);
    end
    i_cmd_taken = 1'b1;
    @(negedge clk);
    i_cmd_taken = 1'b0;
    n_vec++;
    if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL %s taken: valid=%b busy=%b required 0/0", tag, o_cmd_valid, o_busy);
    end
  endtask

  task automatic run_cmd(input string tag, input bit inject_start);
    bit ok;
    pulse_start();
    n_vec++;
    if (o_req !== 1'b1 || o_busy !== 1'b1 || o_bad_opcode !== 1'b0) begin
      n_err++; $display("FAIL %s start: req=%b busy=%b bad=%b required 1/1/0", tag, o_req, o_busy, o_bad_opcode);
    end
    send_bytes(model_len(cmd_q[0]), inject_start, ok);
    if (ok) begin
      @(negedge clk);
      check_done(tag);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({o_req, o_cmd_valid, o_bad_opcode, o_timeout, o_busy} !== 5'b0 ||
        o_cmd_opcode !== 8'h00 || o_cmd_len !== 4'h0) begin
      n_err++; $display("FAIL reset_outputs: got %b/%h/%h required 0/00/0",
                        {o_req, o_cmd_valid, o_bad_opcode, o_timeout, o_busy}, o_cmd_opcode, o_cmd_len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_busy !== 1'b0 || o_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy=%b req=%b required 0/0", o_busy, o_req);
    end
  endtask

  task automatic test_tur();
    cmd_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_cmd("tur", 1'b0);
  endtask

  task automatic test_vendor();
    cmd_q = '{8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_cmd("vendor", 1'b0);
  endtask

  task automatic test_bad_opcode();
    cmd_q = '{8'hF0};
    run_cmd("bad_op", 1'b0);
  endtask

  task automatic test_timeout();
    int t;
    pulse_start();
    t = 0;
    while (o_timeout !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t != 8) begin
      n_err++; $display("FAIL timeout_delay: got %0d cycles required 8", t);
    end
    n_vec++;
    if (o_req !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_idle: req=%b busy=%b required 0/0", o_req, o_busy);
    end
    @(negedge clk);
    n_vec++;
    if (o_timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: got %b required 0", o_timeout);
    end
  endtask

  task automatic test_abort();
    bit ok;
    cmd_q = '{8'h28, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    pulse_start();
    send_bytes(3, 1'b0, ok);
    @(negedge clk);
    i_abort = 1'b1;
    i_ack   = 1'b1;
    i_db    = 8'hEE;
    @(negedge clk);
    i_abort = 1'b0;
    i_ack   = 1'b0;
    n_vec++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_cmd_valid !== 1'b0 || o_cmd_len !== 4'd0) begin
      n_err++; $display("FAIL abort_idle: req=%b busy=%b valid=%b len=%0d required 0/0/0/0",
                        o_req, o_busy, o_cmd_valid, o_cmd_len);
    end
    cmd_q = '{8'h28, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    run_cmd("abort_restart", 1'b0);
  endtask

  task automatic test_async_reset();
    bit ok;
    cmd_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    pulse_start();
    send_bytes(2, 1'b0, ok);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset: req=%b busy=%b valid=%b required 0/0/0", o_req, o_busy, o_cmd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (o_req !== 1'b0 || o_cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset_stay: req=%b valid=%b required 0/0", o_req, o_cmd_valid);
    end
  endtask

  // Back-to-back random commands; i_start is also pulsed mid-command and must be ignored.
  task automatic test_back_to_back();
    logic [7:0] op;
    int el;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 4))
        0: op = 8'($urandom_range(8'h00, 8'h1F));
        1: op = 8'($urandom_range(8'h20, 8'h5F));
        2: op = 8'($urandom_range(8'hA0, 8'hBF));
        3: op = 8'($urandom_range(8'hD8, 8'hDF));
        default: op = 8'($urandom_range(0, 255));
      endcase
      el = model_len(op);
      cmd_q.delete();
      cmd_q.push_back(op);
      for (int i = 1; i < el; i++) cmd_q.push_back(8'($urandom_range(0, 255)));
      run_cmd($sformatf("rand%0d", n), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_tur();
    test_vendor();
    test_bad_opcode();
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
